// File: rtl/ultra_sonic_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic ranger.
// Holds the sequencer state encoding, result-word bit positions and round-robin channel pick.
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_RISE,
    MEASURE,
    DONE,
    STALL
  } state_e;

  localparam int RESULT_W    = 32;
  localparam int TIMEOUT_BIT = 31;
  localparam int FRESH_BIT   = 30;
  localparam int MAX_CH      = 16;

  // Next set bit of mask strictly after cur, wrapping modulo num_ch.
  // A mask holding only cur wraps all the way round and selects cur again.
  function automatic logic [3:0] next_channel(input logic [MAX_CH-1:0] mask,
                                              input logic [3:0]        cur,
                                              input int unsigned       num_ch);
    logic [3:0]  sel;
    logic        found;
    int unsigned idx;
    sel   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = (32'(cur) + i) % num_ch;
      if (!found && (i <= num_ch) && mask[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/us_echo_sync.sv
// Multi-bit flop-chain synchroniser for the asynchronous echo inputs.
// Each bit is synchronised independently; all stages clear to 0 on reset.
module us_echo_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
  // giving a true STAGES-deep chain instead of collapsing into a single flop.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/ultra_sonic_array.sv
// Round-robin HC-SR04 array controller: fires one sensor at a time, times the echo
// pulse with timeout and saturation, keeps a per-channel result word and streams samples.
module ultra_sonic_array
  import ultra_sonic_pkg::*;
#(
  parameter int  NUM_CH         = 4,
  parameter int  COUNT_WIDTH    = 24,
  parameter int  TRIG_CYCLES    = 1000,
  parameter int  TIMEOUT_CYCLES = 1900000,
  parameter int  STALL_CYCLES   = 3000000,
  parameter int  SYNC_STAGES    = 2,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [NUM_CH-1:0]   echo,
  output logic [NUM_CH-1:0]   trigger,
  input  logic [CH_W-1:0]     rd_ch,
  input  logic                rd_ack,
  output logic [RESULT_W-1:0] rd_data,
  output logic                sample_valid,
  output logic [CH_W-1:0]     sample_ch,
  output logic [RESULT_W-1:0] sample_data
);

  localparam int TMR_MAX_A = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > STALL_CYCLES) ? TMR_MAX_A : STALL_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX) + 1;

  localparam logic [TMR_W-1:0] TRIG_LAST  = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STALL_LAST = TMR_W'(STALL_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    to_q, to_d;
  logic [NUM_CH-1:0]       trig_q, trig_d;
  logic [NUM_CH-1:0]       echo_s;
  logic [RESULT_W-1:0]     result_q [NUM_CH];
  logic [RESULT_W-1:0]     done_word;
  logic [CH_W-1:0]         next_ch;
  logic                    echo_sel;
  logic                    run;

  us_echo_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_echo_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .async_i (echo),
    .sync_o  (echo_s)
  );

  assign echo_sel = echo_s[ch_q];
  assign run      = enable && (|ch_mask);
  assign next_ch  = CH_W'(next_channel(MAX_CH'(ch_mask), 4'(ch_q), NUM_CH));

  always_comb begin
    done_word                    = '0;
    done_word[TIMEOUT_BIT]       = to_q;
    done_word[FRESH_BIT]         = 1'b1;
    done_word[COUNT_WIDTH-1:0]   = cnt_q;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          ch_d    = next_ch;
          tmr_d   = '0;
          state_d = TRIGGER;
        end
      end
      TRIGGER: begin
        if (tmr_q == TRIG_LAST) begin
          tmr_d   = '0;
          state_d = WAIT_RISE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (echo_sel) begin
          cnt_d   = COUNT_WIDTH'(1);
          to_d    = 1'b0;
          tmr_d   = tmr_q + 1'b1;
          state_d = MEASURE;
        end else if (tmr_q >= TO_LAST) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      MEASURE: begin
        // Echo fall wins over a coincident timeout: the pulse did end in time.
        if (!echo_sel) begin
          to_d    = 1'b0;
          state_d = DONE;
        end else if (tmr_q >= TO_LAST) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        tmr_d   = '0;
        state_d = STALL;
      end
      STALL: begin
        if (tmr_q == STALL_LAST) begin
          tmr_d = '0;
          if (run) begin
            ch_d    = next_ch;
            state_d = TRIGGER;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Trigger is decoded from next state so the GPIO pins come straight off flops.
  always_comb begin
    trig_d = '0;
    if (state_d == TRIGGER) trig_d[ch_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      ch_q    <= CH_W'(NUM_CH - 1);
      tmr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      trig_q  <= trig_d;
    end
  end

  // NOTE: the result bank is bus-visible state, so it is reset explicitly; a reset
  // mid-run must not leave stale measurements readable.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((state_q == DONE) && (ch_q == CH_W'(i))) begin
          result_q[i] <= done_word;
        end else if (rd_ack && (rd_ch == CH_W'(i))) begin
          result_q[i][FRESH_BIT] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_data = result_q[i];
    end
  end

  assign trigger      = trig_q;
  assign sample_valid = (state_q == DONE);
  assign sample_ch    = sample_valid ? ch_q : '0;
  assign sample_data  = sample_valid ? done_word : '0;

  trig_onehot_a : assert property (@(posedge clk) disable iff (!reset_l) $onehot0(trigger));

endmodule

// File: doc/ultra_sonic_array.md
Name: ultra_sonic_array

Overview:
- Multi-channel successor to the single-sensor ultrasonic ranger.
- Drives NUM_CH HC-SR04-style sensors in round-robin so only one transducer fires at a time, which avoids acoustic crosstalk.
- Measures each echo pulse width in clk cycles, with timeout detection and saturation.
- Holds one result register per channel for the memory-mapped bus, and emits a per-sample streaming pulse.

Parameters:
- NUM_CH, 4, number of sensor channels (1..16).
- COUNT_WIDTH, 24, echo counter width; must be 30 or less.
- TRIG_CYCLES, 1000, trigger high time in clk cycles (20 us at 50 MHz).
- TIMEOUT_CYCLES, 1900000, maximum cycles from trigger fall to echo fall (38 ms).
- STALL_CYCLES, 3000000, quiet time between consecutive firings (60 ms).
- SYNC_STAGES, 2, echo synchroniser depth (2 or more).

Ports:
- clk  in  1  50 MHz clock.
- reset_l  in  1  reset; asynchronous, active-low.
- enable  in  1  run ranging when 1.
- ch_mask  in  NUM_CH  channels included in the rotation.
- echo  in  NUM_CH  raw echo inputs from GPIO (asynchronous).
- trigger  out  NUM_CH  trigger outputs to GPIO.
- rd_ch  in  CH_W=max(1,$clog2(NUM_CH))  channel select for the bus read.
- rd_ack  in  1  one-cycle pulse; clears the fresh flag of channel rd_ch.
- rd_data  out  32  result of channel rd_ch (combinational mux).
- sample_valid  out  1  one-cycle pulse when a measurement completes.
- sample_ch  out  CH_W  channel index of the completed sample.
- sample_data  out  32  result word of the completed sample.

Behaviour:
- Result word layout:
  - bit31 = timeout.
  - bit30 = fresh.
  - bits[29:COUNT_WIDTH] = 0.
  - bits[COUNT_WIDTH-1:0] = count.
- Reset values:
  - trigger = 0, sample_valid = 0, sample_ch = 0, sample_data = 0.
  - All result registers = 0; FSM in IDLE; current channel index = NUM_CH-1, so the first channel selected is the lowest enabled one.
- Echo synchronisation: each echo bit passes through a SYNC_STAGES flop chain. All echo decisions use the synchronised value, which adds SYNC_STAGES cycles of latency; the count is unaffected because both edges are delayed equally.
- Channel selection: the next channel is the next set bit of ch_mask strictly after the current index, wrapping modulo NUM_CH. The selection is made in IDLE and in STALL exit.
- FSM transitions:
  - IDLE: if enable=1 and ch_mask is nonzero, latch the selected channel and go to TRIGGER. Otherwise stay; trigger = 0.
  - TRIGGER: trigger[ch] = 1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The timeout timer is cleared on entry to WAIT_RISE.
  - WAIT_RISE: on sync echo[ch] = 1, go to MEASURE with count = 1. If the timeout timer reaches TIMEOUT_CYCLES first, go to DONE with timeout = 1 and count = 0.
  - MEASURE: count increments each cycle while echo[ch] = 1 and saturates at all-ones (no wrap).
    - Echo falling goes to DONE with timeout = 0.
    - The timeout timer reaching TIMEOUT_CYCLES goes to DONE with timeout = 1 and count equal to the value held.
  - DONE: lasts one cycle.
    - Write result[ch] = {timeout, 1, count}.
    - Pulse sample_valid, and drive sample_ch and sample_data with the same values in that cycle.
    - Go to STALL.
  - STALL: wait STALL_CYCLES cycles with all triggers at 0.
    - Then, if enable=1 and ch_mask is nonzero, select the next channel and go to TRIGGER.
    - Otherwise go to IDLE.
- Echo on unselected channels is ignored.
- ch_mask and enable changes take effect only at IDLE or STALL exit; a measurement in progress always completes through STALL.
- A ch_mask bit cleared mid-measurement does not abort that channel's sample.
- rd_ack clears the fresh bit (bit30) of result[rd_ch].
  - If DONE writes the same channel in the same cycle, the DONE write wins and fresh stays 1.
  - rd_ack to a channel not being written clears that channel normally in the same cycle.
- At most one trigger bit is high at any time (one-hot or zero).
- Asynchronous reset mid-operation immediately forces trigger = 0 and clears all results.
- Timers are sized $clog2 of their maximum plus 1; they do not wrap.

Decomposition:
- Package ultra_sonic_pkg:
  - FSM state enum (IDLE, TRIGGER, WAIT_RISE, MEASURE, DONE, STALL).
  - Result-word bit positions (TIMEOUT_BIT=31, FRESH_BIT=30).
  - Helper function next_channel(mask, cur).
- Sub-module us_echo_sync: a parametrised-width, SYNC_STAGES-deep synchroniser with reset to 0, instantiated once with width NUM_CH.

Test Plan:
All scenarios use NUM_CH=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, STALL_CYCLES=20.
- Single channel: ch_mask=0001, enable=1, echo0 high for 37 cycles after trigger fall -> trigger0 high for exactly 4 cycles; sample_valid pulses once with sample_ch=0, sample_data=0x40000025; rd_ch=0 reads 0x40000025.
- Round-robin: ch_mask=1011, each channel echoes 10+ch cycles -> trigger order 0,1,3,0,...; samples 0x4000000A, 0x4000000B, 0x4000000D; trigger2 never asserts; at most one trigger high at any time.
- No echo: echo held 0 -> DONE 100 cycles after trigger fall; result 0xC0000000. Echo stuck high -> timeout=1 and count held at timeout.
- rd_ack collision: issue rd_ack on rd_ch=0 in the DONE cycle of channel 0 -> fresh stays 1. Issue rd_ack later -> rd_data=0x00000025.
- Enable drop: deassert enable during MEASURE -> sample still completes, full STALL elapses, FSM returns to IDLE, no further triggers. ch_mask=0000 with enable=1 -> stays IDLE.
- Reset mid-MEASURE: pull reset_l low asynchronously -> trigger=0 and all rd_data=0 within the same cycle. After release, ranging restarts at the lowest enabled channel.
